// File: rtl/frame_writer.sv
// Double-buffered 16x16 bit frame writer: a point stream paints the back buffer,
// frame_end swaps it to the front. Define FRAME_WRITER_XOR_EN to toggle points instead of setting them.
module frame_writer #(
    parameter int FRAME_COUNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [7:0]               point_coord,
    input  logic                     point_valid,
    input  logic                     frame_end,
    output logic                     point_ready,
    input  logic [3:0]               rd_row,
    output logic [15:0]              rd_data,
    output logic [FRAME_COUNT_W-1:0] frame_count,
    output logic                     busy
);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        ACCEPT = 2'd1,
        SWAP   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [3:0]               r_rowIdx;
    logic                     r_pointReady;
    logic                     r_busy;
    logic                     r_frontSel;
    logic [FRAME_COUNT_W-1:0] r_frameCount;
    logic [15:0]              r_rdData;
    logic [15:0]              r_buf [2][16];

    logic       w_accept;
    logic       w_backSel;
    logic [3:0] w_x;
    logic [3:0] w_y;

    // Ready is only ever high in ACCEPT, so it alone qualifies a write.
    assign w_accept  = point_valid & r_pointReady;
    assign w_backSel = ~r_frontSel;
    assign w_x       = point_coord[3:0];
    assign w_y       = point_coord[7:4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= CLEAR;
            r_rowIdx     <= 4'd0;
            r_pointReady <= 1'b0;
            r_busy       <= 1'b1;
            r_frontSel   <= 1'b0;
            r_frameCount <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_rowIdx <= r_rowIdx + 4'd1;
                    if (r_rowIdx == 4'd15) begin
                        r_state      <= ACCEPT;
                        r_pointReady <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (w_accept && frame_end) begin
                        r_state      <= SWAP;
                        r_pointReady <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                SWAP: begin
                    r_frontSel   <= ~r_frontSel;
                    r_frameCount <= r_frameCount + FRAME_COUNT_W'(1);
                    r_rowIdx     <= 4'd0;
                    r_state      <= CLEAR;
                end
                default: begin
                    r_state      <= CLEAR;
                    r_rowIdx     <= 4'd0;
                    r_pointReady <= 1'b0;
                    r_busy       <= 1'b1;
                end
            endcase
        end
    end

    // After a swap the back buffer is the previous front, so CLEAR wipes the old frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 16; r++) begin
                    r_buf[b][r] <= '0;
                end
            end
        end else if (r_state == CLEAR) begin
            r_buf[w_backSel][r_rowIdx] <= '0;
        end else if (w_accept) begin
`ifdef FRAME_WRITER_XOR_EN
            r_buf[w_backSel][w_y][w_x] <= ~r_buf[w_backSel][w_y][w_x];
`else
            r_buf[w_backSel][w_y][w_x] <= 1'b1;
`endif
        end
    end

    // Sampling the old front select on the SWAP edge returns the pre-swap row.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_buf[r_frontSel][rd_row];
        end
    end

    assign point_ready = r_pointReady;
    assign busy        = r_busy;
    assign frame_count = r_frameCount;
    assign rd_data     = r_rdData;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: a point-set reference model predicts front-buffer rows,
// a monitor process checks every read response. Honours FRAME_WRITER_XOR_EN like the design.
module tb_frame_writer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  point_coord = 8'd0;
    logic        point_valid = 1'b0;
    logic        frame_end = 1'b0;
    logic        point_ready;
    logic [3:0]  rd_row = 4'd0;
    logic [15:0] rd_data;
    logic [7:0]  frame_count;
    logic        busy;

    int assertCount = 0;
    int failCount = 0;

    bit [255:0] modelFront = '0;
    bit [255:0] modelBack = '0;
    bit [255:0] prevFront = '0;
    bit [7:0]   modelCount = '0;

    logic [15:0] expQ[$];
    int          rowQ[$];
    bit          rdEn = 1'b0;

    frame_writer #(.FRAME_COUNT_W(8)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .point_coord(point_coord),
        .point_valid(point_valid),
        .frame_end(frame_end),
        .point_ready(point_ready),
        .rd_row(rd_row),
        .rd_data(rd_data),
        .frame_count(frame_count),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: timed out waiting for point_ready, required 1", name);
    endtask

    function automatic logic [15:0] frontRow(input bit [255:0] pts, input int r);
        return pts[r*16 +: 16];
    endfunction

    // Points index the model directly: coord {y,x} is bit y*16+x of the frame.
    task automatic applyStimulus(input logic [7:0] c, input logic fe, output int waited);
        waited = 0;
        point_coord = c;
        frame_end = fe;
        point_valid = 1'b1;
        while (point_ready !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (point_ready !== 1'b1) begin
            reportTimeout("point accept");
            point_valid = 1'b0;
            frame_end = 1'b0;
            return;
        end
        @(negedge clock);
        point_valid = 1'b0;
        frame_end = 1'b0;
`ifdef FRAME_WRITER_XOR_EN
        modelBack[c] = ~modelBack[c];
`else
        modelBack[c] = 1'b1;
`endif
        if (fe) begin
            prevFront = modelFront;
            modelFront = modelBack;
            modelBack = '0;
            modelCount++;
        end
    endtask

    task automatic waitReady(output int waited);
        waited = 0;
        while (point_ready !== 1'b1 && waited < 60) begin
            @(negedge clock);
            waited++;
        end
        if (point_ready !== 1'b1) reportTimeout("wait ready");
    endtask

    task automatic readRow(input int r, input logic [15:0] exp);
        rd_row = 4'(r);
        rdEn = 1'b1;
        expQ.push_back(exp);
        rowQ.push_back(r);
        @(negedge clock);
        rdEn = 1'b0;
    endtask

    task automatic checkClearSeq();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("point_ready in CLEAR cycle %0d", i), 32'(point_ready), 32'd0);
            checkOutput($sformatf("busy in CLEAR cycle %0d", i), 32'(busy), 32'd1);
            @(negedge clock);
        end
        checkOutput("point_ready after CLEAR", 32'(point_ready), 32'd1);
        checkOutput("busy after CLEAR", 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("point_ready in reset", 32'(point_ready), 32'd0);
        checkOutput("busy in reset", 32'(busy), 32'd1);
        checkOutput("rd_data in reset", 32'(rd_data), 32'd0);
        checkOutput("frame_count in reset", 32'(frame_count), 32'd0);
    endtask

    // Monitor: a read sampled on a rising edge is visible at the following falling edge.
    initial begin
        bit pend;
        int r;
        logic [15:0] exp;
        forever begin
            @(posedge clock);
            pend = rdEn;
            @(negedge clock);
            if (pend) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL rd_data scoreboard: got response 0x%0h, required a queued expectation", rd_data);
                end else begin
                    exp = expQ.pop_front();
                    r = rowQ.pop_front();
                    checkOutput($sformatf("rd_data row %0d", r), 32'(rd_data), 32'(exp));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int n;
        int gap;
        int r;
        logic [7:0] c;

        // Reset state and the initial CLEAR sequence.
        #1 reset_n = 1'b0;
        #1 checkResetValues();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        checkClearSeq();
        checkOutput("frame_count after first CLEAR", 32'(frame_count), 32'(modelCount));

        // Three-point frame; reads around the swap edge see old then new front.
        applyStimulus(8'h00, 1'b0, waited);
        applyStimulus(8'h3F, 1'b0, waited);
        applyStimulus(8'hFF, 1'b1, waited);
        readRow(0, frontRow(prevFront, 0));
        readRow(0, frontRow(modelFront, 0));
        waitReady(waited);
        for (int i = 0; i < 16; i++) readRow(i, frontRow(modelFront, i));
        readRow(3, 16'h8000);
        readRow(15, 16'h8000);
        checkOutput("frame_count after frame 1", 32'(frame_count), 32'(modelCount));

        // Point held during CLEAR waits 17 ready-low cycles; front keeps frame A.
        applyStimulus(8'h12, 1'b1, waited);
        applyStimulus(8'h34, 1'b0, waited);
        checkOutput("ready-low gap after frame_end", 32'(waited), 32'd17);
        readRow(1, frontRow(modelFront, 1));
        readRow(3, frontRow(modelFront, 3));
        applyStimulus(8'h35, 1'b1, waited);
        waitReady(waited);
        readRow(3, frontRow(modelFront, 3));
        readRow(1, frontRow(modelFront, 1));

        // Duplicate point: set keeps it, toggle cancels it.
        applyStimulus(8'h55, 1'b0, waited);
        applyStimulus(8'h55, 1'b0, waited);
        applyStimulus(8'h56, 1'b1, waited);
        waitReady(waited);
`ifdef FRAME_WRITER_XOR_EN
        readRow(5, 16'h0040);
`else
        readRow(5, 16'h0060);
`endif
        readRow(5, frontRow(modelFront, 5));

        // Random frames with idle gaps carrying unqualified frame_end.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 10);
            for (int p = 0; p < n; p++) begin
                c = 8'($urandom);
                applyStimulus(c, (p == n - 1), waited);
                if (p != n - 1) begin
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) begin
                        point_coord = 8'($urandom);
                        frame_end = 1'($urandom);
                        @(negedge clock);
                    end
                    frame_end = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        r = $urandom_range(0, 15);
                        readRow(r, frontRow(modelFront, r));
                    end
                end
            end
            waitReady(waited);
            for (int i = 0; i < 16; i++) readRow(i, frontRow(modelFront, i));
            checkOutput($sformatf("frame_count random frame %0d", f), 32'(frame_count), 32'(modelCount));
        end

        // Asynchronous reset in the middle of a frame.
        for (int p = 0; p < 3; p++) applyStimulus(8'($urandom), 1'b0, waited);
        #2 reset_n = 1'b0;
        #1 checkResetValues();
        modelFront = '0;
        modelBack = '0;
        modelCount = '0;
        @(negedge clock);
        reset_n = 1'b1;
        checkClearSeq();
        for (int i = 0; i < 16; i++) readRow(i, frontRow(modelFront, i));

        // 256 single-point frames wrap the counter back to zero.
        for (int f = 0; f < 256; f++) begin
            applyStimulus(8'($urandom), 1'b1, waited);
            waitReady(waited);
            checkOutput($sformatf("frame_count wrap frame %0d", f), 32'(frame_count), 32'(modelCount));
        end
        checkOutput("frame_count wrapped to zero", 32'(frame_count), 32'd0);
        r = $urandom_range(0, 15);
        readRow(r, frontRow(modelFront, r));

        repeat (3) @(negedge clock);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
